// File: rtl/btc_double_sha256.sv
// btc_double_sha256: iterative Bitcoin block hash SHA-256(SHA-256(header)).
// One SHA-256 round per clock. Three compressions run back to back:
// header block 1, padded header block 2, then the padded 256-bit first digest.
// Optional build macro BUSY_OUT_EN adds a 'busy' status output.
module btc_double_sha256 (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [639:0] blockHeader,
    output logic [255:0] digest,
    output logic         finish
`ifdef BUSY_OUT_EN
    ,
    output logic         busy
`endif
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INIT  = 3'd1,
        ST_ROUND = 3'd2,
        ST_ADD   = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    // SHA-256 initial hash value; H0 sits in the most significant word.
    localparam logic [255:0] SHA_IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    function automatic logic [31:0] big_sigma0(input logic [31:0] x);
        return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
    endfunction

    function automatic logic [31:0] big_sigma1(input logic [31:0] x);
        return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
    endfunction

    function automatic logic [31:0] small_sigma0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    function automatic logic [31:0] small_sigma1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0000000000, x[31:10]};
    endfunction

    function automatic logic [31:0] k_const(input logic [5:0] idx);
        logic [31:0] k;
        case (idx)
            6'd0:  k = 32'h428a2f98;  6'd1:  k = 32'h71374491;  6'd2:  k = 32'hb5c0fbcf;  6'd3:  k = 32'he9b5dba5;
            6'd4:  k = 32'h3956c25b;  6'd5:  k = 32'h59f111f1;  6'd6:  k = 32'h923f82a4;  6'd7:  k = 32'hab1c5ed5;
            6'd8:  k = 32'hd807aa98;  6'd9:  k = 32'h12835b01;  6'd10: k = 32'h243185be;  6'd11: k = 32'h550c7dc3;
            6'd12: k = 32'h72be5d74;  6'd13: k = 32'h80deb1fe;  6'd14: k = 32'h9bdc06a7;  6'd15: k = 32'hc19bf174;
            6'd16: k = 32'he49b69c1;  6'd17: k = 32'hefbe4786;  6'd18: k = 32'h0fc19dc6;  6'd19: k = 32'h240ca1cc;
            6'd20: k = 32'h2de92c6f;  6'd21: k = 32'h4a7484aa;  6'd22: k = 32'h5cb0a9dc;  6'd23: k = 32'h76f988da;
            6'd24: k = 32'h983e5152;  6'd25: k = 32'ha831c66d;  6'd26: k = 32'hb00327c8;  6'd27: k = 32'hbf597fc7;
            6'd28: k = 32'hc6e00bf3;  6'd29: k = 32'hd5a79147;  6'd30: k = 32'h06ca6351;  6'd31: k = 32'h14292967;
            6'd32: k = 32'h27b70a85;  6'd33: k = 32'h2e1b2138;  6'd34: k = 32'h4d2c6dfc;  6'd35: k = 32'h53380d13;
            6'd36: k = 32'h650a7354;  6'd37: k = 32'h766a0abb;  6'd38: k = 32'h81c2c92e;  6'd39: k = 32'h92722c85;
            6'd40: k = 32'ha2bfe8a1;  6'd41: k = 32'ha81a664b;  6'd42: k = 32'hc24b8b70;  6'd43: k = 32'hc76c51a3;
            6'd44: k = 32'hd192e819;  6'd45: k = 32'hd6990624;  6'd46: k = 32'hf40e3585;  6'd47: k = 32'h106aa070;
            6'd48: k = 32'h19a4c116;  6'd49: k = 32'h1e376c08;  6'd50: k = 32'h2748774c;  6'd51: k = 32'h34b0bcb5;
            6'd52: k = 32'h391c0cb3;  6'd53: k = 32'h4ed8aa4a;  6'd54: k = 32'h5b9cca4f;  6'd55: k = 32'h682e6ff3;
            6'd56: k = 32'h748f82ee;  6'd57: k = 32'h78a5636f;  6'd58: k = 32'h84c87814;  6'd59: k = 32'h8cc70208;
            6'd60: k = 32'h90befffa;  6'd61: k = 32'ha4506ceb;  6'd62: k = 32'hbef9a3f7;  6'd63: k = 32'hc67178f2;
            default: k = 32'h00000000;
        endcase
        return k;
    endfunction

    state_e              state_q, state_d;
    logic [5:0]          round_q, round_d;
    logic [1:0]          blk_q, blk_d;
    logic [639:0]        hdr_q, hdr_d;
    // Working variables: index 7 is 'a' down to index 0 is 'h'.
    logic [7:0][31:0]    work_q, work_d;
    // Chaining value: index 7 is H0 down to index 0 is H7.
    logic [7:0][31:0]    hash_q, hash_d;
    // Schedule window: index 15 holds W[t], index 0 holds W[t+15].
    logic [15:0][31:0]   w_q, w_d;
    logic [255:0]        digest_q, digest_d;
    logic                finish_q, finish_d;
    logic                busy_q, busy_d;

    logic [31:0]         t1_s, t2_s, w_new_s;

    // Round datapath: temporaries T1/T2 and the next schedule word.
    always_comb begin
        t1_s    = work_q[0] + big_sigma1(work_q[3])
                + ((work_q[3] & work_q[2]) ^ (~work_q[3] & work_q[1]))
                + k_const(round_q) + w_q[15];
        t2_s    = big_sigma0(work_q[7])
                + ((work_q[7] & work_q[6]) ^ (work_q[7] & work_q[5]) ^ (work_q[6] & work_q[5]));
        w_new_s = small_sigma1(w_q[1]) + w_q[6] + small_sigma0(w_q[14]) + w_q[15];
    end

    // Sequencer: next-state and next-value logic for every register.
    always_comb begin
        state_d  = state_q;
        round_d  = round_q;
        blk_d    = blk_q;
        hdr_d    = hdr_q;
        work_d   = work_q;
        hash_d   = hash_q;
        w_d      = w_q;
        digest_d = digest_q;
        finish_d = 1'b0;
        busy_d   = (state_q != ST_IDLE);

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    hdr_d   = blockHeader;
                    blk_d   = 2'd0;
                    state_d = ST_INIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_INIT: begin
                round_d = 6'd0;
                state_d = ST_ROUND;
                case (blk_q)
                    2'd0: begin
                        w_d    = hdr_q[639:128];
                        work_d = SHA_IV;
                        hash_d = SHA_IV;
                    end
                    2'd1: begin
                        // Tail of the header plus padding for a 640-bit message.
                        w_d    = {hdr_q[127:0], 32'h80000000, 320'h0, 32'h00000280};
                        work_d = hash_q;
                    end
                    default: begin
                        // Second hash: message is the first digest, restart from IV.
                        w_d    = {hash_q, 32'h80000000, 192'h0, 32'h00000100};
                        work_d = SHA_IV;
                        hash_d = SHA_IV;
                    end
                endcase
            end
            ST_ROUND: begin
                work_d[7] = t1_s + t2_s;
                work_d[6] = work_q[7];
                work_d[5] = work_q[6];
                work_d[4] = work_q[5];
                work_d[3] = work_q[4] + t1_s;
                work_d[2] = work_q[3];
                work_d[1] = work_q[2];
                work_d[0] = work_q[1];
                w_d       = {w_q[14:0], w_new_s};
                round_d   = round_q + 6'd1;
                if (round_q == 6'd63) begin
                    state_d = ST_ADD;
                end else begin
                    state_d = ST_ROUND;
                end
            end
            ST_ADD: begin
                for (int i = 0; i < 8; i++) begin
                    hash_d[i] = hash_q[i] + work_q[i];
                end
                if (blk_q == 2'd2) begin
                    state_d = ST_DONE;
                end else begin
                    blk_d   = blk_q + 2'd1;
                    state_d = ST_INIT;
                end
            end
            ST_DONE: begin
                digest_d = hash_q;
                finish_d = 1'b1;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            round_q  <= 6'd0;
            blk_q    <= 2'd0;
            hdr_q    <= 640'h0;
            work_q   <= 256'h0;
            hash_q   <= 256'h0;
            w_q      <= 512'h0;
            digest_q <= 256'h0;
            finish_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            round_q  <= round_d;
            blk_q    <= blk_d;
            hdr_q    <= hdr_d;
            work_q   <= work_d;
            hash_q   <= hash_d;
            w_q      <= w_d;
            digest_q <= digest_d;
            finish_q <= finish_d;
            busy_q   <= busy_d;
        end
    end

    assign digest = digest_q;
    assign finish = finish_q;

`ifdef BUSY_OUT_EN
    assign busy = busy_q;
`else
    logic unused_busy_s;
    assign unused_busy_s = busy_q;
`endif

endmodule

// File: tb/tb_btc_double_sha256.sv
// Directed bench for btc_double_sha256: known Bitcoin headers, input
// isolation, reset abort and back-to-back jobs.
module tb_btc_double_sha256;

    logic         clk;
    logic         reset;
    logic         start;
    logic [639:0] block_header;
    logic [255:0] digest;
    logic         finish;

    int tests;
    int fails;

    typedef struct {
        logic [639:0] hdr;
        logic [255:0] exp;
    } vec_t;

    vec_t vecs[2];

    btc_double_sha256 dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .blockHeader (block_header),
        .digest      (digest),
        .finish      (finish)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // One job: returns after a fixed window, checking latency, pulse count and digest.
    task automatic run_job(input logic [639:0] hdr, input logic [255:0] exp, input string name,
                           input bit disturb, input logic [639:0] alt);
        int lat;
        int pulses;
        logic [255:0] cap;
        lat    = 0;
        pulses = 0;
        cap    = 256'h0;
        block_header = hdr;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int cyc = 1; cyc <= 230; cyc++) begin
            if (disturb && cyc == 20) block_header = alt;
            if (disturb && cyc == 60) start = 1'b1;
            if (disturb && cyc == 62) start = 1'b0;
            tick();
            if (finish === 1'b1) begin
                pulses++;
                if (pulses == 1) begin
                    lat = cyc;
                    cap = digest;
                end
            end
        end
        check({name, " latency"}, 256'(lat), 256'(199));
        check({name, " pulses"}, 256'(pulses), 256'(1));
        check({name, " digest"}, cap, exp);
        check({name, " digest hold"}, digest, exp);
    endtask

    initial begin
        int p;
        int c1;
        int c2;
        int unstable;
        logic [255:0] d0;
        logic [255:0] d1;
        logic [255:0] d2;

        tests = 0;
        fails = 0;

        vecs[0].hdr = {32'h01000000,
                       256'h81cd02ab7e569e8bcd9317e2fe99f2de44d49ab2b8851ba4a308000000000000,
                       256'he320b6c2fffc8d750423db8b1eb942ae710e951ed797f7affc8892b0f1fc122b,
                       96'hc7f5d74df2b9441a42a14695};
        vecs[0].exp = 256'h1dbd981fe6985776b644b173a4d0385ddc1aa2a829688d1e0000000000000000;
        vecs[1].hdr = {32'h01000000,
                       256'h0,
                       256'h3ba3edfd7a7b12b27ac72c3e67768f617fc81bc3888a51323a9fb8aa4b1e5e4a,
                       96'h29ab5f49ffff001d1dac2b7c};
        vecs[1].exp = 256'h6fe28c0ab6f1b372c1a6a246ae63f74f931e8365e15a089c68d6190000000000;

        reset = 1'b1;
        start = 1'b0;
        block_header = 640'h0;
        tick();
        tick();
        reset = 1'b0;
        check("reset digest", digest, 256'h0);
        check("reset finish", 256'(finish), 256'h0);

        for (int i = 0; i < 2; i++) begin
            run_job(vecs[i].hdr, vecs[i].exp, $sformatf("vec%0d", i), 1'b0, 640'h0);
        end

        // Header change and a second start mid-job must not disturb the result.
        run_job(vecs[0].hdr, vecs[0].exp, "isolation", 1'b1, vecs[1].hdr);

        // Reset one cycle at cycle 100 of a job.
        p = 0;
        block_header = vecs[1].hdr;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int cyc = 1; cyc <= 230; cyc++) begin
            if (cyc == 100) reset = 1'b1;
            if (cyc == 101) reset = 1'b0;
            tick();
            if (finish === 1'b1) p++;
        end
        check("abort pulses", 256'(p), 256'(0));
        check("abort digest", digest, 256'h0);
        check("abort finish", 256'(finish), 256'h0);
        run_job(vecs[1].hdr, vecs[1].exp, "after abort", 1'b0, 640'h0);

        // Back-to-back with start held high across two jobs.
        p = 0;
        c1 = 0;
        c2 = 0;
        unstable = 0;
        d0 = digest;
        d1 = 256'h0;
        d2 = 256'h0;
        block_header = vecs[0].hdr;
        start = 1'b1;
        tick();
        block_header = vecs[1].hdr;
        for (int cyc = 1; cyc <= 420; cyc++) begin
            tick();
            if (finish === 1'b1) begin
                p++;
                if (p == 1) begin
                    c1 = cyc;
                    d1 = digest;
                end else if (p == 2) begin
                    c2 = cyc;
                    d2 = digest;
                    start = 1'b0;
                end
            end else if (p == 0 && digest !== d0) begin
                unstable++;
            end else if (p == 1 && digest !== d1) begin
                unstable++;
            end
        end
        check("b2b pulses", 256'(p), 256'(2));
        check("b2b first latency", 256'(c1), 256'(199));
        check("b2b spacing", 256'(c2 - c1), 256'(200));
        check("b2b digest1", d1, vecs[0].exp);
        check("b2b digest2", d2, vecs[1].exp);
        check("b2b digest stable", 256'(unstable), 256'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
